// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router egress path.
//   arb_state_t  : egress arbiter FSM states
//   HDR_LEN_*    : bit positions of the length field inside a header byte
//   NPORTS       : number of router output FIFOs
package router_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      BODY  = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   localparam int unsigned HDR_LEN_MSB = 7;
   localparam int unsigned HDR_LEN_LSB = 2;
   localparam int unsigned NPORTS      = 3;

endpackage

// File: rtl/router_rr_picker.sv
// Combinational 3-way rotating-priority selector.
//   req[2:0]     : per-port request
//   last[1:0]    : most recently served port; search starts at last+1
//   gnt_idx[1:0] : selected port (0 when nothing requests)
//   gnt_any      : at least one request present
module router_rr_picker
   import router_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] gnt_idx,
   output logic       gnt_any
);

   logic [1:0] cand;

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      // visit last+1, last+2, last; first hit wins
      for (int unsigned k = 1; k <= NPORTS; k++) begin
         cand = 2'((32'(last) + k) % NPORTS);
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/router_egress_arbiter.sv
// Round-robin egress scheduler: drains whole packets from the three router
// output FIFOs and merges them onto one 8-bit valid/ready link with framing.
//   clk, rst                 : clock, asynchronous active-high reset
//   vld_out_n / dout_n       : FIFO n non-empty / read data (1-cycle latency)
//   read_enb_n               : FIFO n read strobe (one-hot or zero)
//   out_data/out_valid/out_ready : egress byte handshake
//   out_sop / out_eop        : header byte / parity byte markers
//   out_port                 : currently granted FIFO
//   busy                     : FSM not in IDLE
module router_egress_arbiter
   import router_pkg::*;
#(
   parameter int unsigned LEN_W = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vld_out_0,
   input  logic       vld_out_1,
   input  logic       vld_out_2,
   input  logic [7:0] dout_0,
   input  logic [7:0] dout_1,
   input  logic [7:0] dout_2,
   output logic       read_enb_0,
   output logic       read_enb_1,
   output logic       read_enb_2,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sop,
   output logic       out_eop,
   output logic [1:0] out_port,
   output logic       busy
);

   localparam int unsigned CW = LEN_W + 1;

   arb_state_t    state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d;
   logic          sop_q, sop_d;

   logic [2:0]       req;
   logic [1:0]       pick_idx;
   logic             pick_any;
   logic [7:0]       dout_g;
   logic             vld_g;
   logic [LEN_W-1:0] hdr_len;
   logic [CW-1:0]    remaining;
   logic             accept;
   logic             slot_free;
   logic             rd_fire;

   assign req = {vld_out_2, vld_out_1, vld_out_0};

   router_rr_picker u_picker (
      .req     (req),
      .last    (last_q),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   always_comb begin
      dout_g = dout_0;
      vld_g  = vld_out_0;
      case (grant_q)
         2'd1: begin
            dout_g = dout_1;
            vld_g  = vld_out_1;
         end
         2'd2: begin
            dout_g = dout_2;
            vld_g  = vld_out_2;
         end
         default: begin
            dout_g = dout_0;
            vld_g  = vld_out_0;
         end
      endcase
   end

   assign hdr_len   = LEN_W'(dout_g[HDR_LEN_MSB:HDR_LEN_LSB]);
   assign accept    = out_valid_q & out_ready;
   assign slot_free = ~out_valid_q | out_ready;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      sop_d       = sop_q;
      rd_fire     = 1'b0;
      remaining   = cnt_q;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               state_d = HDR;
            end
         end
         HDR: begin
            if (vld_g && slot_free) begin
               rd_fire = 1'b1;
               sop_d   = 1'b1;
               state_d = BODY;
            end
         end
         BODY: begin
            // while the header is on the link, the byte count comes
            // straight from it: len payload bytes plus the parity byte
            if (sop_q) begin
               remaining = {1'b0, hdr_len} + CW'(1);
            end
            if (accept) begin
               sop_d = 1'b0;
            end
            if (vld_g && slot_free && (remaining != '0)) begin
               rd_fire = 1'b1;
               if (remaining == CW'(1)) begin
                  state_d = DRAIN;
               end
            end
            cnt_d = remaining - CW'(rd_fire);
         end
         DRAIN: begin
            if (accept) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = out_valid_q;
      if (rd_fire) begin
         out_valid_d = 1'b1;
      end else if (accept) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= 2'd0;
         last_q      <= 2'd2;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         sop_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         sop_q       <= sop_d;
      end
   end

   assign read_enb_0 = rd_fire && (grant_q == 2'd0);
   assign read_enb_1 = rd_fire && (grant_q == 2'd1);
   assign read_enb_2 = rd_fire && (grant_q == 2'd2);
   assign out_data   = dout_g;
   assign out_valid  = out_valid_q;
   assign out_sop    = sop_q;
   assign out_eop    = (state_q == DRAIN) && out_valid_q;
   assign out_port   = grant_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_router_egress_arbiter.sv
module tb_router_egress_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic [7:0] dout_0, dout_1, dout_2;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_sop, out_eop;
   logic [1:0] out_port;
   logic       busy;

   always #5 clk = ~clk;

   router_egress_arbiter #(.LEN_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .vld_out_0  (vld_out_0),
      .vld_out_1  (vld_out_1),
      .vld_out_2  (vld_out_2),
      .dout_0     (dout_0),
      .dout_1     (dout_1),
      .dout_2     (dout_2),
      .read_enb_0 (read_enb_0),
      .read_enb_1 (read_enb_1),
      .read_enb_2 (read_enb_2),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_port   (out_port),
      .busy       (busy)
   );

   // ---------------- FIFO models (1-cycle read latency, output held) -----
   logic [7:0]  mem [3][4096];
   int unsigned wp [3];
   int unsigned rp [3];
   logic [7:0]  dq [3];
   logic [2:0]  hold = 3'b000;
   logic        flush = 1'b0;
   logic [2:0]  re;
   logic [2:0]  vld;

   assign re        = {read_enb_2, read_enb_1, read_enb_0};
   assign vld_out_0 = (wp[0] != rp[0]) && !hold[0];
   assign vld_out_1 = (wp[1] != rp[1]) && !hold[1];
   assign vld_out_2 = (wp[2] != rp[2]) && !hold[2];
   assign vld       = {vld_out_2, vld_out_1, vld_out_0};
   assign dout_0    = dq[0];
   assign dout_1    = dq[1];
   assign dout_2    = dq[2];

   always @(posedge clk) begin
      for (int n = 0; n < 3; n++) begin
         if (flush) begin
            rp[n] <= wp[n];
         end else if (re[n] && (wp[n] != rp[n])) begin
            dq[n] <= mem[n][rp[n]];
            rp[n] <= rp[n] + 1;
         end
      end
   end

   // ---------------- reference model / scoreboard -------------------------
   typedef struct packed {
      logic [7:0] d;
      logic [1:0] p;
      logic       s;
      logic       e;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] pb[3][$];
   int         pl[3][$];
   int         mlast = 2;

   int checks = 0;
   int errors = 0;

   int   cyc = 0;
   logic stall_prev = 1'b0;
   logic [7:0] pd;
   logic [1:0] pport;
   logic psop, peop;
   logic idle_due = 1'b0;
   logic gap_chk = 1'b0;
   int   last_eop_cyc = -1;
   int   rdcnt [3];
   int   rdfirst [3];
   int   rdlast [3];
   logic rnd_rdy = 1'b0;
   logic rdy_force = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req_v, $time);
      end
   endtask

   task automatic put(input int p, input logic [7:0] b);
      mem[p][wp[p]] = b;
      wp[p]++;
      pb[p].push_back(b);
   endtask

   task automatic load_pkt(input int p, input int len);
      logic [5:0] l6;
      logic [1:0] p2;
      logic [7:0] b, par;
      l6  = len[5:0];
      p2  = p[1:0];
      par = {l6, p2};
      put(p, par);
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         put(p, b);
         par = par ^ b;
      end
      put(p, par);
      pl[p].push_back(len + 2);
   endtask

   // Whole packets go out in round-robin order over the ports that hold them.
   task automatic sched();
      bit   found;
      int   p, n;
      exp_t e;
      do begin
         found = 0;
         for (int k = 1; k <= 3; k++) begin
            p = (mlast + k) % 3;
            if (pl[p].size() > 0) begin
               n = pl[p].pop_front();
               for (int i = 0; i < n; i++) begin
                  e.d = pb[p].pop_front();
                  e.p = p[1:0];
                  e.s = (i == 0);
                  e.e = (i == n - 1);
                  expq.push_back(e);
               end
               mlast = p;
               found = 1;
               break;
            end
         end
      end while (found);
   endtask

   task automatic clr_rd();
      for (int n = 0; n < 3; n++) begin
         rdcnt[n]   = 0;
         rdfirst[n] = -1;
         rdlast[n]  = -1;
      end
   endtask

   task automatic wait_idle(input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (expq.size() == 0 && !busy && wp[0] == rp[0] && wp[1] == rp[1] && wp[2] == rp[2])
            return;
      end
      checks++;
      errors++;
      $display("FAIL %s: not drained after %0d cycles, %0d bytes outstanding", nm, budget, expq.size());
   endtask

   task automatic wait_sop(input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (out_valid && out_sop) return;
      end
      checks++;
      errors++;
      $display("FAIL %s: no header within %0d cycles, got out_valid=%0b expected 1", nm, budget, out_valid);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            stall_prev = 1'b0;
            idle_due   = 1'b0;
            continue;
         end
         chk("read_onehot", 32'($countones(re) <= 1), 1);
         chk("read_while_stalled", 32'(re != 0 && out_valid && !out_ready), 0);
         if (re != 0) chk("read_port", 32'(re), 32'(3'b001 << out_port));
         for (int n = 0; n < 3; n++) begin
            if (re[n]) begin
               chk("read_when_empty", 32'(vld[n]), 1);
               rdcnt[n]++;
               if (rdfirst[n] < 0) rdfirst[n] = cyc;
               rdlast[n] = cyc;
            end
         end
         if (idle_due) begin
            chk("busy_after_eop", 32'(busy), 0);
            idle_due = 1'b0;
         end
         if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'(pd));
            chk("stall_port", 32'(out_port), 32'(pport));
            chk("stall_sop", 32'(out_sop), 32'(psop));
            chk("stall_eop", 32'(out_eop), 32'(peop));
         end
         stall_prev = out_valid && !out_ready;
         pd    = out_data;
         pport = out_port;
         psop  = out_sop;
         peop  = out_eop;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h on port %0d, expected no byte", out_data, out_port);
            end else begin
               e = expq.pop_front();
               chk("egress_data", 32'(out_data), 32'(e.d));
               chk("egress_port", 32'(out_port), 32'(e.p));
               chk("egress_sop", 32'(out_sop), 32'(e.s));
               chk("egress_eop", 32'(out_eop), 32'(e.e));
            end
            if (out_sop && gap_chk && last_eop_cyc >= 0)
               chk("packet_gap", 32'(cyc - last_eop_cyc), 3);
            if (out_eop) begin
               idle_due     = 1'b1;
               last_eop_cyc = cyc;
            end
         end
      end
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge clk); #2;
         out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_read_enb"}, 32'(re), 0);
      chk({nm, "_out_valid"}, 32'(out_valid), 0);
      chk({nm, "_out_sop"}, 32'(out_sop), 0);
      chk({nm, "_out_eop"}, 32'(out_eop), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_out_port"}, 32'(out_port), 0);
   endtask

   task automatic stimulus();
      logic pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // three ports, two len-1 packets each: 0,1,2,0,1,2 with 2 idle cycles
      gap_chk      = 1'b1;
      last_eop_cyc = -1;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 3; p++) load_pkt(p, 1);
      sched();
      wait_idle(200, "rr_rounds");
      gap_chk = 1'b0;

      // single packet on port 1, header 0x0D
      clr_rd();
      load_pkt(1, 3);
      sched();
      wait_idle(100, "single_pkt");
      chk("single_reads_p1", 32'(rdcnt[1]), 5);
      chk("single_reads_span", 32'(rdlast[1] - rdfirst[1]), 4);
      chk("single_reads_p0p2", 32'(rdcnt[0] + rdcnt[2]), 0);

      // len 0 packet, header 0x02
      clr_rd();
      load_pkt(2, 0);
      sched();
      wait_idle(100, "len0_pkt");
      chk("len0_reads", 32'(rdcnt[2]), 2);

      // out_ready 1,0,0,1 during the body of a len 8 packet
      clr_rd();
      load_pkt(0, 8);
      sched();
      wait_sop(20, "stall_hdr");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         rdy_force = pat[i];
      end
      @(posedge clk); #1;
      rdy_force = 1'b1;
      wait_idle(100, "stall_pkt");
      chk("stall_reads", 32'(rdcnt[0]), 10);

      // port 2 FIFO runs dry for 4 cycles while port 0 waits
      load_pkt(2, 10);
      sched();
      wait_sop(20, "dry_hdr");
      load_pkt(0, 2);
      sched();
      repeat (2) begin @(posedge clk); #1; end
      hold[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("dry_port_kept", 32'(out_port), 2);
         chk("dry_busy", 32'(busy), 1);
         chk("dry_no_read", 32'(read_enb_2), 0);
         @(posedge clk); #1;
      end
      hold[2] = 1'b0;
      wait_idle(200, "dry_pkt");

      // randomized batches with random backpressure
      rnd_rdy = 1'b1;
      for (int b = 0; b < 4; b++) begin
         if (b == 0) load_pkt(1, 63);
         for (int p = 0; p < 3; p++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) load_pkt(p, $urandom_range(0, 20));
         end
         sched();
         wait_idle(4000, "random_batch");
      end
      rnd_rdy = 1'b0;
      repeat (2) @(posedge clk);

      // reset in the middle of a len 20 packet on port 1
      #1;
      load_pkt(1, 20);
      sched();
      wait_sop(20, "rst_hdr");
      repeat (5) begin @(posedge clk); #1; end
      chk("rst_pre_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      flush = 1'b1;
      expq.delete();
      for (int p = 0; p < 3; p++) begin
         pl[p].delete();
         pb[p].delete();
      end
      mlast = 2;
      @(posedge clk); #1;
      flush = 1'b0;
      rst   = 1'b0;
      clr_rd();
      load_pkt(0, 3);
      sched();
      #1;
      chk("post_rst_no_read", 32'(read_enb_0), 0);
      @(posedge clk); #1;
      chk("post_rst_hdr_read", 32'(read_enb_0), 1);
      wait_idle(100, "post_rst_pkt");
      chk("post_rst_reads", 32'(rdcnt[0]), 5);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      clr_rd();
      fork
         monitor();
         ready_drv();
         stimulus();
         begin
            #500000;
            $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
            $fatal(1, "watchdog expired");
         end
      join_any
      disable fork;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
